mcp3008_slave_model: RTL and testbench

MCP3008_SLAVE_MODEL -- requirements
Module: mcp3008_slave_model

---
 rtl/mcp3008_pkg.sv | 20 ++
 rtl/spi_edge_sync.sv | 41 ++++
 rtl/mcp3008_slave_model.sv | 144 ++++++++++++++
 tb/tb_mcp3008_slave_model.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcp3008_pkg.sv
// Shared constants and state encoding for the MCP3008 SPI slave model.
package mcp3008_pkg;

  localparam int unsigned ADC_BITS       = 10;
  localparam int unsigned CMD_BITS       = 4;
  localparam int unsigned DATA_PHASE_CNT = 10;
  localparam int unsigned TRAIL_CNT      = 9;
  localparam int unsigned CNT_BITS       = 4;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    SAMPLE,
    NULLB,
    DATA,
    TRAIL,
    DONE
  } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Brings sclk/CE_N/MOSI into the clk_50M domain and flags sclk edges.
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_50M,
  input  logic rst,
  input  logic sclk,
  input  logic ce_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ce_n_s,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] ce_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_prev;

  // Presets match the idle bus (sclk high, chip deselected) so reset creates no edges.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      sclk_q    <= '1;
      ce_q      <= '1;
      mosi_q    <= '0;
      sclk_prev <= 1'b1;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
      ce_q      <= {ce_q[SYNC_STAGES-2:0], ce_n};
      mosi_q    <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = ~sclk_prev & sclk_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_prev & ~sclk_q[SYNC_STAGES-1];
  assign ce_n_s    = ce_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/mcp3008_slave_model.sv
// Behavioural-accurate MCP3008 SPI slave: decodes the channel command and
// shifts back a null bit plus the 10-bit sample (optionally LSB-first trailer).
module mcp3008_slave_model
  import mcp3008_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TRAIL_LSB   = 0
) (
  input  logic                clk_50M,
  input  logic                rst,
  input  logic                sclk,
  input  logic                CE_N,
  input  logic                MOSI,
  output logic                MISO,
  output logic                miso_oe,
  input  logic [ADC_BITS-1:0] sample_in,
  output logic [2:0]          ch_sel,
  output logic                sgl_diff,
  output logic                cmd_valid,
  output logic                busy
);

  logic                  sclk_rise;
  logic                  sclk_fall;
  logic                  ce_n_s;
  logic                  mosi_s;
  state_t                state;
  logic [CNT_BITS-1:0]   bit_cnt;
  logic [CMD_BITS-2:0]   cmd_q;
  logic [ADC_BITS-1:0]   shift_q;
  logic [SYNC_STAGES-1:0] settle_q;
  logic                  armed;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_50M   (clk_50M),
    .rst       (rst),
    .sclk      (sclk),
    .ce_n      (CE_N),
    .mosi      (MOSI),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ce_n_s    (ce_n_s),
    .mosi_s    (mosi_s)
  );

  // A frame may only start once a genuine (post-flush) CE_N high has been seen.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      settle_q <= '0;
      armed    <= 1'b0;
    end else begin
      settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      if (settle_q[SYNC_STAGES-1] && ce_n_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      cmd_q     <= '0;
      shift_q   <= '0;
      MISO      <= 1'b0;
      miso_oe   <= 1'b0;
      ch_sel    <= '0;
      sgl_diff  <= 1'b0;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      if (ce_n_s) begin
        state   <= IDLE;
        bit_cnt <= '0;
        MISO    <= 1'b0;
        miso_oe <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (armed && sclk_rise && mosi_s) begin
              state   <= CMD;
              busy    <= 1'b1;
              bit_cnt <= '0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              cmd_q <= {cmd_q[CMD_BITS-3:0], mosi_s};
              if (bit_cnt == CNT_BITS'(CMD_BITS - 1)) begin
                sgl_diff  <= cmd_q[2];
                ch_sel    <= {cmd_q[1:0], mosi_s};
                cmd_valid <= 1'b1;
                bit_cnt   <= '0;
                state     <= SAMPLE;
              end else begin
                bit_cnt <= bit_cnt + CNT_BITS'(1);
              end
            end
          end
          SAMPLE: begin
            if (sclk_fall) begin
              MISO    <= 1'b0;
              miso_oe <= 1'b1;
              shift_q <= sample_in;
              bit_cnt <= '0;
              state   <= NULLB;
            end
          end
          NULLB, DATA: begin
            // Rotate so the register holds the original sample again after B0.
            if (sclk_fall) begin
              MISO    <= shift_q[ADC_BITS-1];
              shift_q <= {shift_q[ADC_BITS-2:0], shift_q[ADC_BITS-1]};
              if (bit_cnt == CNT_BITS'(DATA_PHASE_CNT - 1)) begin
                bit_cnt <= '0;
                state   <= (TRAIL_LSB != 0) ? TRAIL : DONE;
              end else begin
                bit_cnt <= bit_cnt + CNT_BITS'(1);
                state   <= DATA;
              end
            end
          end
          TRAIL: begin
            if (sclk_fall) begin
              MISO    <= shift_q[1];
              shift_q <= shift_q >> 1;
              if (bit_cnt == CNT_BITS'(TRAIL_CNT - 1)) begin
                bit_cnt <= '0;
                state   <= DONE;
              end else begin
                bit_cnt <= bit_cnt + CNT_BITS'(1);
              end
            end
          end
          DONE: begin
            if (sclk_fall) MISO <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcp3008_slave_model.sv
// Scoreboard bench: one default instance and one with 3 sync stages plus LSB trailer.
module tb_mcp3008_slave_model;

  localparam int unsigned S0   = 2;
  localparam int unsigned S1   = 3;
  localparam int unsigned HALF = 5;

  logic       clk_50M = 1'b0;
  logic       rst     = 1'b1;
  logic       sclk    = 1'b1;
  logic       CE_N    = 1'b1;
  logic       MOSI    = 1'b0;
  logic [9:0] sample_in = 10'h000;

  logic       miso0, oe0, sgl0, cv0, busy0;
  logic       miso1, oe1, sgl1, cv1, busy1;
  logic [2:0] ch0, ch1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] q_bit0[$];
  logic [1:0] q_bit1[$];
  logic [3:0] q_cmd0[$];
  logic [3:0] q_cmd1[$];

  always #10 clk_50M = ~clk_50M;

  mcp3008_slave_model #(.SYNC_STAGES(S0), .TRAIL_LSB(0)) u_dut0 (
    .clk_50M(clk_50M), .rst(rst), .sclk(sclk), .CE_N(CE_N), .MOSI(MOSI),
    .MISO(miso0), .miso_oe(oe0), .sample_in(sample_in), .ch_sel(ch0),
    .sgl_diff(sgl0), .cmd_valid(cv0), .busy(busy0)
  );

  mcp3008_slave_model #(.SYNC_STAGES(S1), .TRAIL_LSB(1)) u_dut1 (
    .clk_50M(clk_50M), .rst(rst), .sclk(sclk), .CE_N(CE_N), .MOSI(MOSI),
    .MISO(miso1), .miso_oe(oe1), .sample_in(sample_in), .ch_sel(ch1),
    .sgl_diff(sgl1), .cmd_valid(cv1), .busy(busy1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {miso_oe, MISO} at the k-th master sampling (rising) edge of a frame.
  function automatic logic [1:0] exp_rise(input int k, input int lead,
                                          input logic [9:0] smp, input bit trail);
    int r;
    r = k - (lead + 5);
    if (r < 0) return 2'b00;
    if (r == 0) return 2'b10;
    if (r <= 10) return {1'b1, smp[10 - r]};
    if (trail && r <= 19) return {1'b1, smp[r - 10]};
    return 2'b10;
  endfunction

  task automatic check_bit(input int d, input logic [1:0] act);
    logic [1:0] e;
    if ((d == 0 && q_bit0.size() == 0) || (d == 1 && q_bit1.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL bit dut%0d: unexpected sclk rise, got oe/miso %b", d, act);
      return;
    end
    e = (d == 0) ? q_bit0.pop_front() : q_bit1.pop_front();
    chk($sformatf("oe_miso dut%0d", d), int'(act), int'(e));
  endtask

  task automatic check_cmd(input int d, input logic [3:0] act);
    logic [3:0] e;
    if ((d == 0 && q_cmd0.size() == 0) || (d == 1 && q_cmd1.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cmd dut%0d: unexpected cmd_valid, sgl_ch %h", d, act);
      return;
    end
    e = (d == 0) ? q_cmd0.pop_front() : q_cmd1.pop_front();
    chk($sformatf("sgl_ch dut%0d", d), int'(act), int'(e));
  endtask

  // Monitors: master-side MISO sampling and command decode pulses.
  always @(posedge sclk) begin
    if (CE_N === 1'b0 && rst === 1'b0) begin
      check_bit(0, {oe0, miso0});
      check_bit(1, {oe1, miso1});
    end
  end

  always @(negedge clk_50M) begin
    if (cv0 === 1'b1) check_cmd(0, {sgl0, ch0});
    if (cv1 === 1'b1) check_cmd(1, {sgl1, ch1});
  end

  task automatic half();
    repeat (HALF) @(negedge clk_50M);
  endtask

  task automatic sclk_cycle(input logic mosi_b, input logic [1:0] e0, input logic [1:0] e1);
    q_bit0.push_back(e0);
    q_bit1.push_back(e1);
    sclk = 1'b0;
    MOSI = mosi_b;
    half();
    sclk = 1'b1;
    half();
  endtask

  task automatic end_frame(input bit oe_was);
    CE_N = 1'b1;
    for (int c = 1; c <= int'(S1) + 1; c++) begin
      @(posedge clk_50M);
      #1;
      if (oe_was && c == int'(S0)) chk("oe_hold dut0", int'(oe0), 1);
      if (c == int'(S0) + 1) begin
        chk("oe_off dut0", int'(oe0), 0);
        chk("busy_off dut0", int'(busy0), 0);
      end
      if (oe_was && c == int'(S1)) chk("oe_hold dut1", int'(oe1), 1);
      if (c == int'(S1) + 1) begin
        chk("oe_off dut1", int'(oe1), 0);
        chk("miso_off dut1", int'(miso1), 0);
      end
    end
    half();
    half();
  endtask

  task automatic frame(input int lead, input logic sgl, input logic [2:0] ch,
                       input logic [9:0] smp, input int n_resp, input bit chg,
                       input logic [9:0] smp2, input bit keep);
    int k;
    logic [4:0] cmd;
    k   = 0;
    cmd = {1'b1, sgl, ch};
    q_cmd0.push_back({sgl, ch});
    q_cmd1.push_back({sgl, ch});
    sample_in = smp;
    CE_N = 1'b0;
    half();
    for (int i = 0; i < lead; i++) begin
      sclk_cycle(1'b0, exp_rise(k, lead, smp, 1'b0), exp_rise(k, lead, smp, 1'b1));
      k++;
    end
    for (int i = 4; i >= 0; i--) begin
      sclk_cycle(cmd[i], exp_rise(k, lead, smp, 1'b0), exp_rise(k, lead, smp, 1'b1));
      k++;
    end
    chk("busy_in_frame dut0", int'(busy0), 1);
    chk("busy_in_frame dut1", int'(busy1), 1);
    for (int i = 0; i < n_resp; i++) begin
      sclk_cycle(1'b0, exp_rise(k, lead, smp, 1'b0), exp_rise(k, lead, smp, 1'b1));
      k++;
      if (chg && i == 0) sample_in = smp2;
    end
    if (!keep) end_frame(n_resp > 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst miso dut0", int'(miso0), 0);
    chk("rst oe dut0", int'(oe0), 0);
    chk("rst ch dut0", int'(ch0), 0);
    chk("rst sgl dut0", int'(sgl0), 0);
    chk("rst cv dut0", int'(cv0), 0);
    chk("rst busy dut0", int'(busy0), 0);
    chk("rst miso dut1", int'(miso1), 0);
    chk("rst oe dut1", int'(oe1), 0);
    chk("rst ch dut1", int'(ch1), 0);
    chk("rst sgl dut1", int'(sgl1), 0);
    chk("rst cv dut1", int'(cv1), 0);
    chk("rst busy dut1", int'(busy1), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] fake;
    repeat (3) @(negedge clk_50M);
    check_reset_outputs();
    rst = 1'b0;
    half();
    half();

    // Channel 3 single-ended, with and without leading zeros, then trailer data.
    frame(0, 1'b1, 3'd3, 10'h2A5, 13, 1'b0, 10'h000, 1'b0);
    frame(2, 1'b1, 3'd3, 10'h2A5, 13, 1'b0, 10'h000, 1'b0);
    frame(0, 1'b1, 3'd0, 10'h001, 22, 1'b0, 10'h000, 1'b0);

    // Abort after B5, then a full-scale frame on channel 7.
    frame(1, 1'b0, 3'd5, 10'h2C3, 6, 1'b0, 10'h000, 1'b0);
    frame(0, 1'b1, 3'd7, 10'h3FF, 13, 1'b0, 10'h000, 1'b0);

    // sample_in changes after the null bit must not disturb the frame.
    frame(0, 1'b1, 3'd2, 10'h155, 22, 1'b1, 10'h0AA, 1'b0);

    // Reset in the data phase with CE_N held low: no new command may be decoded.
    frame(0, 1'b0, 3'd6, 10'h1E7, 4, 1'b0, 10'h000, 1'b1);
    rst = 1'b1;
    @(posedge clk_50M);
    #1;
    check_reset_outputs();
    half();
    rst = 1'b0;
    half();
    fake = 5'b11011;
    for (int i = 4; i >= 0; i--) sclk_cycle(fake[i], 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) sclk_cycle(1'b0, 2'b00, 2'b00);
    chk("post_rst busy dut0", int'(busy0), 0);
    chk("post_rst busy dut1", int'(busy1), 0);
    CE_N = 1'b1;
    half();
    half();
    frame(0, 1'b0, 3'd4, 10'h0F0, 13, 1'b0, 10'h000, 1'b0);

    // Randomized frames, some aborted early.
    for (int n = 0; n < 24; n++) begin
      int lead, nr;
      bit chg;
      lead = int'($urandom_range(0, 3));
      nr   = ($urandom_range(0, 1) == 1) ? 22 : int'($urandom_range(0, 21));
      chg  = $urandom_range(0, 1) == 1;
      frame(lead, 1'($urandom), 3'($urandom), 10'($urandom), nr, chg, 10'($urandom), 1'b0);
    end

    chk("bit queue dut0 drained", q_bit0.size(), 0);
    chk("bit queue dut1 drained", q_bit1.size(), 0);
    chk("cmd queue dut0 drained", q_cmd0.size(), 0);
    chk("cmd queue dut1 drained", q_cmd1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
